// File: rtl/v_pkg.sv
// v_pkg: shared types for the list-state engine update path.
// Update payload layout, command codes and ingress FSM states.
package v_pkg;

   typedef logic [7:0]  id_t;
   typedef logic [15:0] key_t;
   typedef logic [15:0] size_t;

   typedef enum logic [1:0] {
      CMD_ADD = 2'd0,
      CMD_MOD = 2'd1,
      CMD_DEL = 2'd2,
      CMD_CLR = 2'd3
   } cmd_t;

   typedef struct packed {
      id_t   prod_id;
      cmd_t  cmd;
      key_t  key;
      size_t size;
   } upd_t;

   localparam int UPD_BITS = $bits(upd_t);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } ingress_state_t;

endpackage

// File: rtl/v_upd_fifo.sv
// v_upd_fifo: flop-array FIFO with occupancy counter and a
// registered ready that looks one cycle ahead at occupancy.
module v_upd_fifo
   import v_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int W     = UPD_BITS,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             i_push,
   input  logic [W-1:0]     i_data,
   input  logic             i_pop,
   output logic [W-1:0]     o_data,
   output logic             o_rdy_r,
   output logic [OCC_W-1:0] o_occ_r,
   output logic [OCC_W-1:0] o_occ_nxt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] ONE  = OCC_W'(1);
   localparam logic [PTR_W-1:0] PONE = PTR_W'(1);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;
   logic             r_rdy;
   logic [OCC_W-1:0] w_occ_nxt;
   logic             w_push;
   logic             w_pop;

   assign w_push    = i_push & r_rdy;
   assign w_pop     = i_pop & (r_occ != '0);
   assign o_data    = r_mem[r_rd_ptr];
   assign o_rdy_r   = r_rdy;
   assign o_occ_r   = r_occ;
   assign o_occ_nxt = w_occ_nxt;

   // Next occupancy; push and pop together leave it unchanged
   always_comb begin
      w_occ_nxt = r_occ;
      unique case ({w_push, w_pop})
         2'b10:   w_occ_nxt = r_occ + ONE;
         2'b01:   w_occ_nxt = r_occ - ONE;
         default: w_occ_nxt = r_occ;
      endcase
   end

   // Payload storage; contents need no reset, pointers guard validity
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally (power-of-two depth), ready looks ahead
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_rdy    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PONE;
         r_occ <= w_occ_nxt;
         r_rdy <= (w_occ_nxt < FULL);
      end
   end

endmodule

// File: rtl/v_upd_ingress.sv
// v_upd_ingress: queues feed updates and issues them to v once
// v has finished its post-reset init; tracks occupancy and HWM.
module v_upd_ingress
   import v_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             i_in_vld,
   input  id_t              i_in_prod_id,
   input  cmd_t             i_in_cmd,
   input  key_t             i_in_key,
   input  size_t            i_in_size,
   output logic             o_in_rdy_r,
   input  logic             i_busy,
   output logic             o_upd_vld_r,
   output id_t              o_upd_prod_id_r,
   output cmd_t             o_upd_cmd_r,
   output key_t             o_upd_key_r,
   output size_t            o_upd_size_r,
   input  logic             i_hwm_clr,
   output logic [OCC_W-1:0] o_occ_r,
   output logic [OCC_W-1:0] o_hwm_r
);

   ingress_state_t r_state;
   ingress_state_t w_state_nxt;
   logic           w_issue_ok;
   logic           w_push;
   logic           w_pop;
   upd_t           w_in_upd;
   logic [UPD_BITS-1:0] w_rd_data;
   logic [OCC_W-1:0]    w_occ;
   logic [OCC_W-1:0]    w_occ_nxt;
   logic                w_rdy;
   upd_t                r_upd;
   logic                r_upd_vld;
   logic [OCC_W-1:0]    r_hwm;

   assign w_in_upd = {i_in_prod_id, i_in_cmd, i_in_key, i_in_size};
   assign w_push   = i_in_vld & w_rdy;
   assign w_pop    = w_issue_ok & (w_occ != '0);

   v_upd_fifo #(
      .DEPTH (DEPTH),
      .W     (UPD_BITS)
   ) u_fifo (
      .clk       (clk),
      .arst_n    (arst_n),
      .i_push    (w_push),
      .i_data    (w_in_upd),
      .i_pop     (w_pop),
      .o_data    (w_rd_data),
      .o_rdy_r   (w_rdy),
      .o_occ_r   (w_occ),
      .o_occ_nxt (w_occ_nxt)
   );

   // Issue gate state: wait for v to go busy, then idle, then run
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) r_state <= BOOT;
      else         r_state <= w_state_nxt;
   end

   // Next state; issue only while running and v not busy
   always_comb begin
      w_state_nxt = r_state;
      w_issue_ok  = 1'b0;
      unique case (r_state)
         BOOT:    if (i_busy)  w_state_nxt = ARMED;
         ARMED:   if (!i_busy) w_state_nxt = RUN;
         RUN:     w_issue_ok = ~i_busy;
         default: w_state_nxt = BOOT;
      endcase
   end

   // Issue register: one-cycle valid per popped entry, payload holds
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_upd_vld <= 1'b0;
         r_upd     <= '0;
      end else begin
         r_upd_vld <= w_pop;
         if (w_pop) r_upd <= upd_t'(w_rd_data);
      end
   end

   // High-water mark; clear loads next occupancy and wins over max
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)               r_hwm <= '0;
      else if (i_hwm_clr)        r_hwm <= w_occ_nxt;
      else if (w_occ_nxt > r_hwm) r_hwm <= w_occ_nxt;
   end

   assign o_in_rdy_r      = w_rdy;
   assign o_occ_r         = w_occ;
   assign o_hwm_r         = r_hwm;
   assign o_upd_vld_r     = r_upd_vld;
   assign o_upd_prod_id_r = r_upd.prod_id;
   assign o_upd_cmd_r     = r_upd.cmd;
   assign o_upd_key_r     = r_upd.key;
   assign o_upd_size_r    = r_upd.size;

endmodule

// File: tb/tb_v_upd_ingress.sv
// tb_v_upd_ingress: directed bench for the v update ingress buffer.
// Scoreboards issued payloads against accepted ones, in order.
`timescale 1ns/1ps
module tb_v_upd_ingress;
   import v_pkg::*;

   localparam int DEPTH = 16;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             arst_n = 1'b0;
   logic             i_in_vld = 1'b0;
   id_t              i_in_prod_id = '0;
   cmd_t             i_in_cmd = CMD_ADD;
   key_t             i_in_key = '0;
   size_t            i_in_size = '0;
   logic             o_in_rdy_r;
   logic             i_busy = 1'b0;
   logic             o_upd_vld_r;
   id_t              o_upd_prod_id_r;
   cmd_t             o_upd_cmd_r;
   key_t             o_upd_key_r;
   size_t            o_upd_size_r;
   logic             i_hwm_clr = 1'b0;
   logic [OCC_W-1:0] o_occ_r;
   logic [OCC_W-1:0] o_hwm_r;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   logic [UPD_BITS-1:0] obs_q[$];
   logic [UPD_BITS-1:0] exp_q[$];

   v_upd_ingress #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .arst_n          (arst_n),
      .i_in_vld        (i_in_vld),
      .i_in_prod_id    (i_in_prod_id),
      .i_in_cmd        (i_in_cmd),
      .i_in_key        (i_in_key),
      .i_in_size       (i_in_size),
      .o_in_rdy_r      (o_in_rdy_r),
      .i_busy          (i_busy),
      .o_upd_vld_r     (o_upd_vld_r),
      .o_upd_prod_id_r (o_upd_prod_id_r),
      .o_upd_cmd_r     (o_upd_cmd_r),
      .o_upd_key_r     (o_upd_key_r),
      .o_upd_size_r    (o_upd_size_r),
      .i_hwm_clr       (i_hwm_clr),
      .o_occ_r         (o_occ_r),
      .o_hwm_r         (o_hwm_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (arst_n && o_upd_vld_r) begin
         if (pulse_cnt == 0) first_cyc = cyc;
         last_cyc = cyc;
         pulse_cnt++;
         obs_q.push_back({o_upd_prod_id_r, o_upd_cmd_r,
                          o_upd_key_r, o_upd_size_r});
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear();
      obs_q.delete();
      exp_q.delete();
      pulse_cnt = 0;
   endtask

   task automatic push(input logic [7:0] id, input logic [1:0] c,
                       input logic [15:0] k, input logic [15:0] s);
      logic acc;
      bit   done;
      done = 1'b0;
      i_in_vld     = 1'b1;
      i_in_prod_id = id;
      i_in_cmd     = cmd_t'(c);
      i_in_key     = k;
      i_in_size    = s;
      for (int i = 0; i < 40 && !done; i++) begin
         acc = o_in_rdy_r;
         tick();
         if (acc) begin
            done = 1'b1;
            exp_q.push_back({id, c, k, s});
         end
      end
      i_in_vld = 1'b0;
      chk("push_accept", 64'(done), 1);
   endtask

   task automatic wait_pulses(input int n, input int bound);
      for (int i = 0; i < bound && pulse_cnt < n; i++) tick();
   endtask

   task automatic cmp_q(input string tag);
      int mism;
      int n;
      mism = 0;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (obs_q[i] !== exp_q[i]) mism++;
      chk({tag, "_order"}, mism, 0);
      clear();
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      ticks(2);
      arst_n = 1'b1;
      clear();
   endtask

   initial begin
      logic acc;
      bit   done;
      int   fall;
      int   occ_bad;
      int   miss;

      // reset state, then a push with v never busy stays queued
      ticks(2);
      chk("rst_rdy", o_in_rdy_r, 0);
      chk("rst_vld", o_upd_vld_r, 0);
      chk("rst_occ", o_occ_r, 0);
      chk("rst_hwm", o_hwm_r, 0);
      arst_n = 1'b1;
      tick();
      chk("rdy_after_rst", o_in_rdy_r, 1);
      push(8'h11, 2'd0, 16'h1111, 16'h0001);
      ticks(20);
      chk("t1_no_issue", pulse_cnt, 0);
      chk("t1_occ", o_occ_r, 1);

      // busy window, three pushes, issue once busy falls
      do_reset();
      i_busy = 1'b1;
      tick();
      push(8'h21, 2'd1, 16'h2101, 16'h0021);
      push(8'h22, 2'd2, 16'h2202, 16'h0022);
      push(8'h23, 2'd3, 16'h2303, 16'h0023);
      ticks(4);
      chk("t2_held", pulse_cnt, 0);
      chk("t2_occ", o_occ_r, 3);
      i_busy = 1'b0;
      fall = cyc;
      wait_pulses(3, 20);
      ticks(2);
      chk("t2_first_lat", 64'(first_cyc - fall), 2);
      chk("t2_consec", 64'(last_cyc - first_cyc), 2);
      chk("t2_occ_end", o_occ_r, 0);
      cmp_q("t2");

      // single-entry latency in RUN
      push(8'h30, 2'd1, 16'h005A, 16'h0030);
      chk("t3_occ_n", o_occ_r, 1);
      chk("t3_vld_n", o_upd_vld_r, 0);
      tick();
      chk("t3_vld", o_upd_vld_r, 1);
      chk("t3_key", o_upd_key_r, 16'h005A);
      chk("t3_occ", o_occ_r, 0);
      tick();
      chk("t3_pulse_end", o_upd_vld_r, 0);
      chk("t3_key_hold", o_upd_key_r, 16'h005A);
      cmp_q("t3");

      // fill to full while paused, 17th held until busy drops
      i_busy = 1'b1;
      for (int i = 0; i < 16; i++)
         push(8'(64 + i), 2'(i), 16'(32'h4000 + i), 16'(i));
      chk("t4_occ", o_occ_r, 16);
      chk("t4_rdy", o_in_rdy_r, 0);
      chk("t4_hwm", o_hwm_r, 16);
      i_in_vld     = 1'b1;
      i_in_prod_id = 8'h50;
      i_in_cmd     = CMD_DEL;
      i_in_key     = 16'h4010;
      i_in_size    = 16'h0010;
      ticks(3);
      chk("t4_held_occ", o_occ_r, 16);
      chk("t4_held_cnt", pulse_cnt, 0);
      i_busy = 1'b0;
      tick();
      chk("t4_rdy_back", o_in_rdy_r, 1);
      chk("t4_occ15", o_occ_r, 15);
      done = 1'b0;
      for (int i = 0; i < 5 && !done; i++) begin
         acc = o_in_rdy_r;
         tick();
         if (acc) begin
            done = 1'b1;
            exp_q.push_back({8'h50, 2'd2, 16'h4010, 16'h0010});
         end
      end
      i_in_vld = 1'b0;
      chk("t4_acc17", 64'(done), 1);
      wait_pulses(17, 60);
      ticks(2);
      cmp_q("t4");

      // steady push+pop at occupancy 5
      i_busy = 1'b1;
      for (int i = 0; i < 5; i++)
         push(8'(96 + i), 2'(i), 16'(32'h6000 + i), 16'(i));
      chk("t5_occ_start", o_occ_r, 5);
      i_busy   = 1'b0;
      occ_bad  = 0;
      miss     = 0;
      i_in_vld = 1'b1;
      for (int i = 0; i < 100; i++) begin
         i_in_prod_id = 8'(i);
         i_in_cmd     = cmd_t'(2'(i));
         i_in_key     = 16'(32'h5000 + i);
         i_in_size    = 16'(3 * i);
         acc = o_in_rdy_r;
         tick();
         if (acc) exp_q.push_back({8'(i), 2'(i), 16'(32'h5000 + i),
                                   16'(3 * i)});
         else miss++;
         if (o_occ_r != 5) occ_bad++;
      end
      i_in_vld = 1'b0;
      chk("t5_occ_const", occ_bad, 0);
      chk("t5_rdy_miss", miss, 0);
      wait_pulses(105, 40);
      ticks(2);
      cmp_q("t5");

      // reset mid-operation discards queue; HWM clear
      i_busy = 1'b1;
      for (int i = 0; i < 7; i++)
         push(8'(112 + i), 2'(i), 16'(32'h7000 + i), 16'(i));
      chk("t6_occ7", o_occ_r, 7);
      #2;
      arst_n = 1'b0;
      #1;
      chk("t6_rst_occ", o_occ_r, 0);
      chk("t6_rst_rdy", o_in_rdy_r, 0);
      chk("t6_rst_vld", o_upd_vld_r, 0);
      chk("t6_rst_hwm", o_hwm_r, 0);
      chk("t6_rst_key", o_upd_key_r, 0);
      ticks(2);
      arst_n = 1'b1;
      clear();
      tick();
      i_busy = 1'b0;
      ticks(20);
      chk("t6_no_stale", pulse_cnt, 0);
      chk("t6_occ0", o_occ_r, 0);
      i_busy = 1'b1;
      for (int i = 0; i < 5; i++)
         push(8'(128 + i), 2'(i), 16'(32'h8000 + i), 16'(i));
      i_busy = 1'b0;
      wait_pulses(5, 20);
      ticks(2);
      cmp_q("t6a");
      chk("t6_hwm5", o_hwm_r, 5);
      i_busy = 1'b1;
      for (int i = 0; i < 3; i++)
         push(8'(144 + i), 2'(i), 16'(32'h9000 + i), 16'(i));
      chk("t6_occ3", o_occ_r, 3);
      chk("t6_hwm_keep", o_hwm_r, 5);
      i_hwm_clr = 1'b1;
      tick();
      i_hwm_clr = 1'b0;
      chk("t6_hwm_clr", o_hwm_r, 3);
      push(8'h9F, 2'd1, 16'h9FFF, 16'h0001);
      chk("t6_hwm_grow", o_hwm_r, 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
